// File: rtl/seg7_bcd_ctrl.sv
// seg7_bcd_ctrl: sequential double-dabble binary-to-BCD converter with leading-zero blanking for seg7 digits
module seg7_bcd_ctrl #(
  parameter int WIDTH = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   digits
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;
  state_t state, state_n;
  logic [4*DIGITS-1:0] bcd, adj, disp;
  logic [WIDTH-1:0] bin;
  logic [CW-1:0] cnt;
  logic [DIGITS:0] nz;
  logic sticky, lz;
  assign nz[DIGITS] = 1'b0;
  genvar i;
  generate
    for (i = 0; i < DIGITS; i++) begin : g_dig
      assign adj[4*i+:4] = bcd[4*i+:4] >= 4'd5 ? bcd[4*i+:4] + 4'd3 : bcd[4*i+:4];
      // nz[i]: some nibble at or above digit i is nonzero
      assign nz[i] = nz[i+1] | (bcd[4*i+:4] != 4'd0);
      assign disp[4*i+:4] = (sticky || (lz && i != 0 && !nz[i])) ? 4'hF : bcd[4*i+:4];
    end
  endgenerate
  always_comb begin
    state_n = (state == IDLE && start) ? SHIFT :
              (state == SHIFT && cnt == '0) ? FIN :
              (state == FIN) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      overflow <= 1'b0;
      digits <= '1;
      bcd <= '0;
      bin <= '0;
      cnt <= '0;
      sticky <= 1'b0;
      lz <= 1'b0;
    end else begin
      state <= state_n;
      busy <= state_n != IDLE;
      done <= state == FIN;
      if (state == IDLE && start) begin
        bin <= value;
        lz <= blank_lz;
        bcd <= '0;
        sticky <= 1'b0;
        cnt <= CW'(WIDTH - 1);
      end
      if (state == SHIFT) begin
        {bcd, bin} <= {adj[4*DIGITS-2:0], bin, 1'b0};
        sticky <= sticky | adj[4*DIGITS-1];
        cnt <= cnt - 1'b1;
      end
      if (state == FIN) begin
        digits <= disp;
        overflow <= sticky;
      end
    end
  end
endmodule

// File: tb/tb_seg7_bcd_ctrl.sv
// tb_seg7_bcd_ctrl: directed checks of conversion, blanking, overflow, start handling and reset abort
module tb_seg7_bcd_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start5 = 1'b0, start4 = 1'b0;
  logic [15:0] value = '0;
  logic blank_lz = 1'b0;
  logic busy5, done5, ovf5, busy4, done4, ovf4;
  logic [19:0] digits5;
  logic [15:0] digits4;
  int checks = 0;
  int errors = 0;
  int lat, ndone, first;

  always #5 clk = ~clk;

  seg7_bcd_ctrl #(.WIDTH(16), .DIGITS(5)) dut5 (
    .clk(clk), .rst(rst), .start(start5), .value(value), .blank_lz(blank_lz),
    .busy(busy5), .done(done5), .overflow(ovf5), .digits(digits5)
  );
  seg7_bcd_ctrl #(.WIDTH(16), .DIGITS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .value(value), .blank_lz(blank_lz),
    .busy(busy4), .done(done4), .overflow(ovf4), .digits(digits4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; asserts start for one cycle and waits for done (bounded).
  task automatic conv(input bit four, input logic [15:0] v, input bit lz, output int l);
    logic [19:0] prev;
    prev = four ? {4'h0, digits4} : digits5;
    value = v;
    blank_lz = lz;
    if (four) start4 = 1'b1; else start5 = 1'b1;
    l = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start5 = 1'b0;
      start4 = 1'b0;
      value = 16'hDEAD;
      blank_lz = ~lz;
      if (k == 1) check("busy_after_start", four ? busy4 : busy5, 1);
      if (k == 9) check("digits_hold", four ? {4'h0, digits4} : digits5, prev);
      if (four ? done4 : done5) begin
        l = k;
        break;
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_digits5", digits5, 20'hFFFFF);
    check("rst_busy5", busy5, 0);
    check("rst_done5", done5, 0);
    check("rst_ovf5", ovf5, 0);
    check("rst_digits4", digits4, 16'hFFFF);
    rst = 1'b0;
    @(negedge clk);

    conv(0, 16'd12345, 0, lat);
    check("lat_12345", lat, 18);
    check("dig_12345", digits5, 20'h12345);
    check("ovf_12345", ovf5, 0);
    @(negedge clk);
    check("done_pulse_one_cycle", done5, 0);
    check("digits_hold_after", digits5, 20'h12345);

    conv(0, 16'd65535, 0, lat);
    check("dig_65535", digits5, 20'h65535);
    conv(0, 16'd42, 1, lat);
    check("dig_42_lz", digits5, 20'hFFF42);
    conv(0, 16'd0, 1, lat);
    check("dig_0_lz", digits5, 20'hFFFF0);
    conv(0, 16'd0, 0, lat);
    check("dig_0", digits5, 20'h00000);
    conv(0, 16'd100, 1, lat);
    check("dig_100_lz", digits5, 20'hFF100);
    check("busy_done_cycle", busy5, 0);

    conv(1, 16'd10000, 0, lat);
    check("lat4", lat, 18);
    check("ovf4_10000", ovf4, 1);
    check("dig4_10000", digits4, 16'hFFFF);
    conv(1, 16'd9999, 1, lat);
    check("ovf4_9999", ovf4, 0);
    check("dig4_9999", digits4, 16'h9999);
    check("dut5_untouched", digits5, 20'hFF100);

    // start in cycle 3 must be dropped
    value = 16'd111;
    blank_lz = 1'b0;
    start5 = 1'b1;
    ndone = 0;
    first = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start5 = (k == 3);
      value = (k == 3) ? 16'd999 : 16'd111;
      if (done5) begin
        ndone++;
        if (first == 0) first = k;
      end
    end
    check("ignored_ndone", ndone, 1);
    check("ignored_first", first, 18);
    check("ignored_digits", digits5, 20'h00111);

    // back-to-back: second start in the done cycle
    conv(0, 16'd2024, 0, lat);
    check("b2b_lat1", lat, 18);
    conv(0, 16'd7, 1, lat);
    check("b2b_lat2", lat, 18);
    check("b2b_digits", digits5, 20'hFFFF7);

    // reset in cycle 5 aborts
    value = 16'd777;
    start5 = 1'b1;
    ndone = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      start5 = 1'b0;
      if (k == 5) rst = 1'b1;
      if (k == 6) begin
        check("rst_abort_busy", busy5, 0);
        rst = 1'b0;
      end
      if (done5) ndone++;
    end
    check("rst_abort_ndone", ndone, 0);
    check("rst_abort_digits", digits5, 20'hFFFFF);
    check("rst_abort_ovf", ovf5, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
